aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_subword.sv | 12 +
 rtl/aes_key_expand.sv | 96 +++++++++
 tb/tb_aes_key_expand.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: schedule sizing, round constants,
// controller state codes and the forward S-box.
package aes_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   function automatic int nw_of(input int nk);
      return 4 * (nk + 7);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int j = 1; j < n; j++) r = xtime(r);
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: the S-box applied independently to each byte of a 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] data,
   output logic [31:0] result
);

   assign result = {sbox(data[31:24]), sbox(data[23:16]),
                    sbox(data[15:8]),  sbox(data[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion, one schedule word per cycle, with a
// combinational round-key read port over the stored schedule.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [32*NK-1:0]  key,
   input  logic [3:0]        rk_idx,
   output logic              busy,
   output logic              valid,
   output logic [127:0]      rk_data
);

   localparam int         NR         = nr_of(NK);
   localparam int         NW         = nw_of(NK);
   localparam logic [5:0] NK_W       = 6'(NK);
   localparam logic [5:0] LAST_W     = 6'(NW - 1);
   localparam logic [2:0] LAST_PHASE = 3'(NK - 1);
   localparam logic [3:0] NR_IDX     = 4'(NR);

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [2:0]  phase;
   logic [7:0]  rcon_q;
   logic [31:0] w [NW];
   logic [31:0] prev;
   logic [31:0] older;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] t;
   logic [31:0] next_word;
   logic [5:0]  base;
   logic        launch;

   assign launch = start && (state != ST_EXPAND);
   assign busy   = (state == ST_EXPAND);
   assign valid  = (state == ST_DONE);

   // phase tracks i mod NK so no divider is needed; rcon_q holds Rcon[i/NK].
   always_comb begin
      prev      = w[cnt - 6'd1];
      older     = w[cnt - NK_W];
      sub_in    = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
      t         = prev;
      if (phase == 3'd0)
         t = sub_out ^ {rcon_q, 24'h000000};
      else if (NK == 8 && phase == 3'd4)
         t = sub_out;
      next_word = older ^ t;
   end

   aes_subword u_subword (
      .data   (sub_in),
      .result (sub_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         phase  <= '0;
         rcon_q <= rcon(1);
      end else if (launch) begin
         state  <= ST_EXPAND;
         cnt    <= NK_W;
         phase  <= '0;
         rcon_q <= rcon(1);
      end else if (state == ST_EXPAND) begin
         if (phase == 3'd0) rcon_q <= xtime(rcon_q);
         phase <= (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
         if (cnt == LAST_W) state <= ST_DONE;
         else               cnt   <= cnt + 6'd1;
      end
   end

   // Schedule storage is deliberately not reset; valid gates its use.
   always_ff @(posedge clk) begin
      if (!rst && launch) begin
         for (int k = 0; k < NK; k++) w[6'(k)] <= key[32*(NK-1-k) +: 32];
      end else if (!rst && state == ST_EXPAND) begin
         w[cnt] <= next_word;
      end
   end

   always_comb begin
      base    = {rk_idx, 2'b00};
      rk_data = '0;
      if (rk_idx <= NR_IDX)
         rk_data = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand at NK = 4, 6 and 8 against a
// FIPS-197 key-schedule model with an S-box derived from GF(2^8) inverses.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         start4, start6, start8;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;
   logic [3:0]   idx4, idx6, idx8;
   logic         busy4, busy6, busy8;
   logic         valid4, valid6, valid8;
   logic [127:0] data4, data6, data8;

   int passed = 0;
   int total  = 0;

   logic [7:0]  tb_sbox [256];
   logic [31:0] ref_w [60];

   aes_key_expand #(.NK(4)) u_nk4 (
      .clk(clk), .rst(rst), .start(start4), .key(key4), .rk_idx(idx4),
      .busy(busy4), .valid(valid4), .rk_data(data4));

   aes_key_expand #(.NK(6)) u_nk6 (
      .clk(clk), .rst(rst), .start(start6), .key(key6), .rk_idx(idx6),
      .busy(busy6), .valid(valid6), .rk_data(data6));

   aes_key_expand #(.NK(8)) u_nk8 (
      .clk(clk), .rst(rst), .start(start8), .key(key8), .rk_idx(idx8),
      .busy(busy8), .valid(valid8), .rk_data(data8));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int j = 0; j < 8; j++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int j = 1; j < n; j++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic build_ref(input int nk, input logic [255:0] k);
      logic [31:0] t;
      for (int i = 0; i < nk; i++) ref_w[i] = k[32*(nk-1-i) +: 32];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         t = ref_w[i-1];
         if (i % nk == 0)
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h000000};
         else if (nk == 8 && i % nk == 4)
            t = sub_word(t);
         ref_w[i] = ref_w[i-nk] ^ t;
      end
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_key(input int sel, input logic [255:0] k);
      case (sel)
         4:       key4 = k[127:0];
         6:       key6 = k[191:0];
         default: key8 = k;
      endcase
   endtask

   task automatic set_start(input int sel, input logic s);
      case (sel)
         4:       start4 = s;
         6:       start6 = s;
         default: start8 = s;
      endcase
   endtask

   function automatic logic get_valid(input int sel);
      case (sel)
         4:       return valid4;
         6:       return valid6;
         default: return valid8;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         4:       return busy4;
         6:       return busy6;
         default: return busy8;
      endcase
   endfunction

   task automatic read_rk(input int sel, input int idx, output logic [127:0] d);
      case (sel)
         4:       idx4 = 4'(idx);
         6:       idx6 = 4'(idx);
         default: idx8 = 4'(idx);
      endcase
      #1;
      case (sel)
         4:       d = data4;
         6:       d = data6;
         default: d = data8;
      endcase
   endtask

   task automatic pulse_start(input int sel, input logic [255:0] k);
      @(negedge clk);
      set_key(sel, k);
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
   endtask

   task automatic wait_valid(input int sel, input int start_cyc, input int exp, input string tag);
      int cyc;
      cyc = start_cyc;
      while (!get_valid(sel) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 128'(cyc), 128'(exp));
      check({tag, " busy after done"}, 128'(get_busy(sel)), 128'(0));
   endtask

   task automatic check_schedule(input int sel, input int nk, input string tag);
      logic [127:0] d;
      for (int r = 0; r <= nk + 6; r++) begin
         read_rk(sel, r, d);
         check($sformatf("%s rk%0d", tag, r), d,
               {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
      end
   endtask

   initial begin
      logic [255:0] k;
      logic [255:0] kb;
      logic [127:0] d;
      int           sel;

      rst = 1'b1;
      start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
      key4 = '0; key6 = '0; key8 = '0;
      idx4 = '0; idx6 = '0; idx8 = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset nk4 busy/valid", 128'({busy4, valid4}), 128'(0));
      check("reset nk6 busy/valid", 128'({busy6, valid6}), 128'(0));
      check("reset nk8 busy/valid", 128'({busy8, valid8}), 128'(0));

      $display("[TB] FIPS-197 NK=4 vector");
      k = 256'(128'h2b7e151628aed2a6abf7158809cf4f3c);
      pulse_start(4, k);
      check("fips4 busy", 128'(busy4), 128'(1));
      build_ref(4, k);
      wait_valid(4, 1, 41, "fips4");
      read_rk(4, 10, d);
      check("fips4 rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(4, 0, d);
      check("fips4 rk0", d, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      check_schedule(4, 4, "fips4");
      for (int r = 11; r <= 15; r++) begin
         read_rk(4, r, d);
         check($sformatf("nk4 rk%0d zero", r), d, 128'h0);
      end

      $display("[TB] FIPS-197 NK=6 vector");
      k = 256'(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
      pulse_start(6, k);
      build_ref(6, k);
      wait_valid(6, 1, 47, "fips6");
      read_rk(6, 12, d);
      check("fips6 w51", 128'(d[31:0]), 128'(32'h01002202));
      check_schedule(6, 6, "fips6");
      read_rk(6, 13, d);
      check("nk6 rk13 zero", d, 128'h0);

      $display("[TB] FIPS-197 NK=8 vector");
      k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      pulse_start(8, k);
      build_ref(8, k);
      wait_valid(8, 1, 53, "fips8");
      read_rk(8, 14, d);
      check("fips8 w59", 128'(d[31:0]), 128'(32'h706c631e));
      check_schedule(8, 8, "fips8");
      read_rk(8, 15, d);
      check("nk8 rk15 zero", d, 128'h0);

      $display("[TB] start during EXPAND is ignored");
      k  = rand_key();
      kb = rand_key();
      pulse_start(4, k);
      repeat (8) @(negedge clk);
      set_key(4, kb);
      set_start(4, 1'b1);
      @(negedge clk);
      set_start(4, 1'b0);
      set_key(4, rand_key());
      check("ignore busy held", 128'(busy4), 128'(1));
      build_ref(4, k);
      wait_valid(4, 10, 41, "ignore");
      check_schedule(4, 4, "ignore");

      $display("[TB] restart from DONE with key changing after start");
      k = rand_key();
      pulse_start(4, k);
      check("restart valid drop", 128'(valid4), 128'(0));
      check("restart busy", 128'(busy4), 128'(1));
      set_key(4, rand_key());
      build_ref(4, k);
      wait_valid(4, 1, 41, "restart");
      check_schedule(4, 4, "restart");

      $display("[TB] reset in the middle of EXPAND");
      pulse_start(6, rand_key());
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst nk6 busy/valid", 128'({busy6, valid6}), 128'(0));
      check("midrst nk4 busy/valid", 128'({busy4, valid4}), 128'(0));
      k = rand_key();
      pulse_start(6, k);
      build_ref(6, k);
      wait_valid(6, 1, 47, "midrst");
      check_schedule(6, 6, "midrst");

      $display("[TB] random keys");
      for (int n = 0; n < 6; n++) begin
         sel = 4 + 2 * (n % 3);
         k = rand_key();
         pulse_start(sel, k);
         build_ref(sel, k);
         wait_valid(sel, 1, 4 * (sel + 7) - sel + 1, $sformatf("rand%0d nk%0d", n, sel));
         check_schedule(sel, sel, $sformatf("rand%0d nk%0d", n, sel));
      end

      $display("[TB] reset has priority over start");
      @(negedge clk);
      rst = 1'b1;
      set_key(4, rand_key());
      set_start(4, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      set_start(4, 1'b0);
      check("rstprio busy/valid", 128'({busy4, valid4}), 128'(0));
      @(negedge clk);
      check("rstprio stays idle", 128'({busy4, valid4}), 128'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
